// File: rtl/clock_timekeeper.sv
// BCD time-of-day core: seconds divider, HH:MM:SS counters and a mode FSM for field edits.
// Optional field blinking in SET modes is built only when CLOCK_BLINK_EN is defined.
module clock_timekeeper #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 1,
    parameter int MAX_HOURS   = 24,
    parameter int BLINK_HZ    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode_pulse,
    input  logic       add_pulse,
    input  logic       sub_pulse,
    output logic [7:0] hours_bcd,
    output logic [7:0] minutes_bcd,
    output logic [7:0] seconds_bcd,
    output logic [1:0] mode,
    output logic [2:0] blink_mask,
    output logic       tick
);

    localparam int DIV_CYCLES = CLK_FREQ_HZ / TICK_HZ;
    localparam int DIV_W      = $clog2(DIV_CYCLES);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_CYCLES - 1);
    localparam logic [7:0] HOURS_MAX = (MAX_HOURS == 12) ? 8'h11 : 8'h23;
    localparam logic [7:0] SIXTY_MAX = 8'h59;

    if ((TICK_HZ < 1) || ((CLK_FREQ_HZ % TICK_HZ) != 0) || (DIV_CYCLES < 2)) begin : g_bad_div
        $error("clock_timekeeper: CLK_FREQ_HZ/TICK_HZ must be an integer >= 2");
    end
    if ((MAX_HOURS != 12) && (MAX_HOURS != 24)) begin : g_bad_hours
        $error("clock_timekeeper: MAX_HOURS must be 12 or 24");
    end
    if ((BLINK_HZ < 1) || ((CLK_FREQ_HZ / (2 * BLINK_HZ)) < 1)) begin : g_bad_blink
        $error("clock_timekeeper: BLINK_HZ out of range");
    end

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_SET_H = 2'd1,
        MODE_SET_M = 2'd2,
        MODE_SET_S = 2'd3
    } mode_t;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v == max_v) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v == 8'h00) begin
            r = max_v;
        end else if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_edit(input logic [7:0] v, input logic [7:0] max_v,
                                            input logic up, input logic dn);
        logic [7:0] r;
        r = v;
        if (up) begin
            r = bcd_inc(v, max_v);
        end else if (dn) begin
            r = bcd_dec(v, max_v);
        end
        return r;
    endfunction

    mode_t            mode_q, mode_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       hours_q, hours_d;
    logic [7:0]       minutes_q, minutes_d;
    logic [7:0]       seconds_q, seconds_d;
    logic             tick_q, tick_d;
    logic             edit_up, edit_dn;

    // A mode pulse wins over a simultaneous edit; add+sub together cancel.
    assign edit_up = add_pulse & ~sub_pulse & ~mode_pulse;
    assign edit_dn = sub_pulse & ~add_pulse & ~mode_pulse;

    always_comb begin
        mode_d    = mode_q;
        div_d     = '0;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        tick_d    = 1'b0;

        unique case (mode_q)
            MODE_RUN: begin
                if (div_q == DIV_LAST) begin
                    tick_d    = 1'b1;
                    seconds_d = bcd_inc(seconds_q, SIXTY_MAX);
                    if (seconds_q == SIXTY_MAX) begin
                        minutes_d = bcd_inc(minutes_q, SIXTY_MAX);
                        if (minutes_q == SIXTY_MAX) begin
                            hours_d = bcd_inc(hours_q, HOURS_MAX);
                        end
                    end
                end else if (!mode_pulse) begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            MODE_SET_H: hours_d   = bcd_edit(hours_q, HOURS_MAX, edit_up, edit_dn);
            MODE_SET_M: minutes_d = bcd_edit(minutes_q, SIXTY_MAX, edit_up, edit_dn);
            MODE_SET_S: seconds_d = bcd_edit(seconds_q, SIXTY_MAX, edit_up, edit_dn);
        endcase

        if (mode_pulse) begin
            mode_d = mode_t'(mode_q + 2'd1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q    <= MODE_RUN;
            div_q     <= '0;
            hours_q   <= 8'h00;
            minutes_q <= 8'h00;
            seconds_q <= 8'h00;
            tick_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            div_q     <= div_d;
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            seconds_q <= seconds_d;
            tick_q    <= tick_d;
        end
    end

    assign hours_bcd   = hours_q;
    assign minutes_bcd = minutes_q;
    assign seconds_bcd = seconds_q;
    assign mode        = mode_q;
    assign tick        = tick_q;

`ifdef CLOCK_BLINK_EN
    localparam int BLINK_CYCLES = CLK_FREQ_HZ / (2 * BLINK_HZ);
    localparam int BLINK_W      = $clog2(BLINK_CYCLES + 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic [2:0]         blink_mask_q, blink_mask_d;

    // Phase restarts visible on every mode change so a newly selected field shows at once.
    always_comb begin
        blink_cnt_d  = '0;
        phase_d      = 1'b0;
        blink_mask_d = 3'b000;
        if (!mode_pulse && (mode_q != MODE_RUN)) begin
            if (blink_cnt_q == BLINK_LAST) begin
                phase_d = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                phase_d     = phase_q;
            end
        end
        unique case (mode_d)
            MODE_RUN:   blink_mask_d = 3'b000;
            MODE_SET_H: blink_mask_d = {phase_d, 2'b00};
            MODE_SET_M: blink_mask_d = {1'b0, phase_d, 1'b0};
            MODE_SET_S: blink_mask_d = {2'b00, phase_d};
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt_q  <= '0;
            phase_q      <= 1'b0;
            blink_mask_q <= 3'b000;
        end else begin
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            blink_mask_q <= blink_mask_d;
        end
    end

    assign blink_mask = blink_mask_q;
`else
    assign blink_mask = 3'b000;
`endif

endmodule

// File: doc/clock_timekeeper.md
# clock_timekeeper

Parametrised time-of-day core for the digital-clock design, replacing the fixed-function counter inside `top`. It divides the system clock into a seconds tick, keeps hours/minutes/seconds in BCD and runs a mode FSM that lets the user edit each field with add/sub pulses. Its BCD outputs feed the seven-segment scanner that drives `AN`/`DIGIT`. Button inputs arrive already debounced and edge-detected upstream.

## Interface
- `CLK_FREQ_HZ`, default 100_000_000: frequency of `clock`.
- `TICK_HZ`, default 1: seconds-tick rate. `CLK_FREQ_HZ/TICK_HZ` must be an integer ≥ 2. Values above 1 are for simulation speed-up.
- `MAX_HOURS`, default 24: hour modulus. Legal values are 12 (counts 0..11) or 24 (counts 0..23).
- `BLINK_HZ`, default 2: blink rate of the edited field. Used only when `CLOCK_BLINK_EN` is defined.
- `clock` input 1: system clock. Everything is rising-edge.
- `reset` input 1: asynchronous, active-high. Clears all state.
- `mode_pulse` input 1: one-cycle pulse that advances the mode FSM.
- `add_pulse` input 1: one-cycle pulse that increments the selected field.
- `sub_pulse` input 1: one-cycle pulse that decrements the selected field.
- `hours_bcd` output 8: tens digit in [7:4], units digit in [3:0].
- `minutes_bcd` output 8: BCD, range 00..59.
- `seconds_bcd` output 8: BCD, range 00..59.
- `mode` output 2: 0 = RUN, 1 = SET_H, 2 = SET_M, 3 = SET_S.
- `blink_mask` output 3: [2] hours, [1] minutes, [0] seconds. High means blank that field.
- `tick` output 1: one-cycle pulse on each seconds tick.

## Operation
- All outputs are registered.
- Reset values: time 00:00:00, `mode` = 0, `blink_mask` = 0, `tick` = 0. The divider and blink phase counters are cleared.
- Divider counts 0..`CLK_FREQ_HZ/TICK_HZ - 1`. Reaching the terminal count produces a tick.
- Divider runs only in RUN. In any SET state it is held at 0, so the first tick after returning to RUN comes one full period later.
- RUN, on each tick:
  - seconds increment;
  - 59→00 carries into minutes;
  - minutes 59→00 carries into hours;
  - hours wrap at `MAX_HOURS-1`→00.
  - All BCD arithmetic is digit-correct: no A–F codes ever appear on any output.
- Mode FSM sequence on `mode_pulse`: RUN→SET_H→SET_M→SET_S→RUN. No other transitions exist.
- In a SET state, `add_pulse` increments the selected field and `sub_pulse` decrements it:
  - the field wraps within its own range (hours 00..`MAX_HOURS-1`, minutes and seconds 00..59);
  - an edit never carries into a neighbouring field.
- In RUN, `add_pulse` and `sub_pulse` are ignored.
- Simultaneous events:
  - `add_pulse` and `sub_pulse` together: no change.
  - `mode_pulse` together with add or sub: mode advances and the edit is discarded.
  - Leaving SET_S and a terminal divider count cannot coincide, because the divider is held in SET states.
- `reset` asserted mid-edit returns immediately (asynchronously) to RUN at 00:00:00.

## Timing
- Pulse sampled at edge N: field or `mode` updates at edge N, visible in cycle N+1. One-cycle latency.
- Divider terminal at edge N: `tick` is high in cycle N+1 and the updated seconds are visible in the same cycle.
- With `TICK_HZ`=1, `CLK_FREQ_HZ`=100 MHz, ticks are 100_000_000 cycles apart.
- Back-to-back pulses on consecutive cycles are each honoured. No minimum spacing is required.

## Configuration
- `CLOCK_BLINK_EN` defined:
  - A phase counter toggles every `CLK_FREQ_HZ/(2*BLINK_HZ)` cycles.
  - In a SET state, the `blink_mask` bit of the selected field equals the phase. All other bits are 0.
  - The phase counter resets to 0, with the field visible, on every mode change, and is held at 0 in RUN.
- `CLOCK_BLINK_EN` undefined: `blink_mask` is constant 0 and no phase counter is built.

## Test plan
Bench parameters for all scenarios: `CLK_FREQ_HZ`=10, `TICK_HZ`=1, `BLINK_HZ`=1.
- Reset, then run 600 cycles → `tick` has pulsed 60 times, time = 00:01:00, `tick` spacing exactly 10 cycles.
- Preload 23:59:59 via edits, return to RUN, wait one tick → 00:00:00. Repeat with `MAX_HOURS`=12: 11:59:59 → 00:00:00.
- SET_M at 00 with `sub_pulse` → 59, hours unchanged. `add_pulse` → 00. `add_pulse` and `sub_pulse` in the same cycle → value unchanged.
- `mode_pulse` and `add_pulse` in the same cycle while in SET_H → mode = SET_M, hours unchanged. Four mode pulses from RUN → back in RUN, divider restarts, first tick 10 cycles later.
- `reset` asserted asynchronously (mid-cycle) while in SET_S at 12:34:56 → outputs 00:00:00 and `mode` = 0 before the next clock edge.
- With `CLOCK_BLINK_EN`, in SET_H: `blink_mask` alternates 3'b000/3'b100 every 5 cycles. Entering SET_M → 3'b000, then 3'b010 after 5 cycles. Without the macro: `blink_mask` is always 0.
